// File: rtl/mem_acc_arbiter.sv
// Memory-port arbiter: round-robin DMA streams, lockable by load/store, read-tag routing.
// Optional starvation guard enabled by defining MEM_ACC_ARB_STARVE_GUARD_EN.
module mem_acc_arbiter #(
  parameter int NUM_DMA      = 4,
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 3,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic [NUM_DMA-1:0]        dma__arb__req,
  input  logic [NUM_DMA-1:0]        dma__arb__we,
  input  logic [NUM_DMA*ADDR_W-1:0] dma__arb__addr,
  input  logic [NUM_DMA*DATA_W-1:0] dma__arb__wdata,
  output logic [NUM_DMA-1:0]        arb__dma__grant,
  output logic [NUM_DMA-1:0]        arb__dma__read_data_valid,
  input  logic                      ldst__arb__request,
  input  logic                      ldst__arb__released,
  input  logic                      ldst__arb__valid,
  input  logic                      ldst__arb__we,
  input  logic [ADDR_W-1:0]         ldst__arb__addr,
  input  logic [DATA_W-1:0]         ldst__arb__wdata,
  output logic                      arb__ldst__granted,
  output logic                      arb__ldst__read_data_valid,
`ifdef MEM_ACC_ARB_STARVE_GUARD_EN
  output logic                      arb__starve_defer,
`endif
  output logic                      arb__mem__valid,
  output logic                      arb__mem__we,
  output logic [ADDR_W-1:0]         arb__mem__addr,
  output logic [DATA_W-1:0]         arb__mem__wdata,
  input  logic [DATA_W-1:0]         mem__arb__rdata,
  output logic [DATA_W-1:0]         arb__rdata
);

  localparam int IDX_W = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;

  if (NUM_DMA < 2 || RD_LAT < 1 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("mem_acc_arbiter: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_DMA, S_DRAIN, S_LDST, S_GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_ptr_nxt;
  logic [NUM_DMA-1:0]  r_round, w_round_nxt;
  logic [NUM_DMA-1:0]  r_grant, w_grant_nxt;
  logic                r_granted, w_granted_nxt;
  logic                r_mem_valid, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [NUM_DMA-1:0]  r_dma_rdv;
  logic                r_ldst_rdv;

  logic                w_any_req, w_sel_found, w_ldst_go, w_defer_act;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_dma_issue, w_ldst_issue, w_mem_load;
  logic                w_mem_valid_nxt, w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt;
  logic                w_tag_vld_in, w_tags_empty;

  // Read-tag pipeline: stage s holds the read issued s cycles ago
  logic [RD_LAT-1:0]   r_tag_vld_p;
  logic                r_tag_ldst_p [RD_LAT];
  logic [IDX_W-1:0]    r_tag_idx_p  [RD_LAT];

  assign w_any_req    = |dma__arb__req;
  assign w_tags_empty = ~|r_tag_vld_p;

  // Round-robin pick: first requester at or after the pointer
  always_comb begin : p_rr
    int k;
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_ptr_nxt   = r_rr_ptr;
    for (int i = 0; i < NUM_DMA; i++) begin
      k = (int'(r_rr_ptr) + i) % NUM_DMA;
      if (!w_sel_found && dma__arb__req[k]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(k);
        w_sel_we    = dma__arb__we[k];
        w_sel_addr  = dma__arb__addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata = dma__arb__wdata[k*DATA_W +: DATA_W];
        w_ptr_nxt   = IDX_W'((k + 1) % NUM_DMA);
      end
    end
  end

  // After a lock, ldst may not re-enter until every stream pending at GAP exit is served
  assign w_ldst_go = ldst__arb__request && !(|r_round) && !w_defer_act;

  always_ff @(posedge clk) begin
    if (reset_poweron) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DMA: begin
        if (w_ldst_go)      w_state_nxt = S_DRAIN;
        else if (w_any_req) w_state_nxt = S_DMA;
        else                w_state_nxt = S_IDLE;
      end
      S_DRAIN: if (w_tags_empty) w_state_nxt = S_LDST;
      S_LDST:  if (ldst__arb__released) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = w_any_req ? S_DMA : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_dma_issue  = w_any_req &&
                   (((r_state == S_IDLE || r_state == S_DMA) && !w_ldst_go) || r_state == S_GAP);
    w_ldst_issue = (r_state == S_LDST) && ldst__arb__valid;
    w_mem_load   = w_dma_issue || (r_state == S_LDST);
    w_grant_nxt  = '0;
    if (w_dma_issue) w_grant_nxt[w_sel_idx] = 1'b1;
    w_mem_valid_nxt = w_dma_issue || w_ldst_issue;
    if (r_state == S_LDST) begin
      w_mem_we_nxt    = ldst__arb__we;
      w_mem_addr_nxt  = ldst__arb__addr;
      w_mem_wdata_nxt = ldst__arb__wdata;
    end else begin
      w_mem_we_nxt    = w_sel_we;
      w_mem_addr_nxt  = w_sel_addr;
      w_mem_wdata_nxt = w_sel_wdata;
    end
    w_granted_nxt = (w_state_nxt == S_LDST);
    w_tag_vld_in  = w_mem_valid_nxt && !w_mem_we_nxt;
    w_round_nxt   = (r_state == S_GAP) ? (dma__arb__req & ~w_grant_nxt) : (r_round & ~w_grant_nxt);
  end

  // Issue stage: grant, memory strobe and tag stage 0 register together
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_rr_ptr    <= '0;
      r_round     <= '0;
      r_grant     <= '0;
      r_granted   <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag_vld_p <= '0;
      r_dma_rdv   <= '0;
      r_ldst_rdv  <= 1'b0;
    end else begin
      if (w_dma_issue) r_rr_ptr <= w_ptr_nxt;
      r_round     <= w_round_nxt;
      r_grant     <= w_grant_nxt;
      r_granted   <= w_granted_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      if (w_mem_load) begin
        r_mem_we    <= w_mem_we_nxt;
        r_mem_addr  <= w_mem_addr_nxt;
        r_mem_wdata <= w_mem_wdata_nxt;
      end
      r_tag_vld_p[0] <= w_tag_vld_in;
      for (int s = 1; s < RD_LAT; s++) r_tag_vld_p[s] <= r_tag_vld_p[s-1];
      // Return stage: last tag becomes the one-hot read-data-valid
      r_dma_rdv  <= '0;
      r_ldst_rdv <= r_tag_vld_p[RD_LAT-1] && r_tag_ldst_p[RD_LAT-1];
      if (r_tag_vld_p[RD_LAT-1] && !r_tag_ldst_p[RD_LAT-1])
        r_dma_rdv[r_tag_idx_p[RD_LAT-1]] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_tag_ldst_p[0] <= (r_state == S_LDST);
    r_tag_idx_p[0]  <= w_sel_idx;
    for (int s = 1; s < RD_LAT; s++) begin
      r_tag_ldst_p[s] <= r_tag_ldst_p[s-1];
      r_tag_idx_p[s]  <= r_tag_idx_p[s-1];
    end
  end

`ifdef MEM_ACC_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]   r_wait_cnt [NUM_DMA];
  logic [NUM_DMA-1:0] r_defer, w_starved, w_defer_mask;
  logic               r_ldst_req_q;

  // Starved set is captured only on the rising edge of the ldst request
  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NUM_DMA; i++) w_starved[i] = (int'(r_wait_cnt[i]) >= STARVE_LIMIT);
    w_defer_mask = (ldst__arb__request && !r_ldst_req_q) ? w_starved : r_defer;
  end

  assign w_defer_act       = |w_defer_mask;
  assign arb__starve_defer = |r_defer;

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_defer      <= '0;
      r_ldst_req_q <= 1'b0;
      for (int i = 0; i < NUM_DMA; i++) r_wait_cnt[i] <= '0;
    end else begin
      r_defer      <= w_defer_mask & ~w_grant_nxt;
      r_ldst_req_q <= ldst__arb__request;
      for (int i = 0; i < NUM_DMA; i++) begin
        if (w_grant_nxt[i])
          r_wait_cnt[i] <= '0;
        else if (dma__arb__req[i] && int'(r_wait_cnt[i]) < STARVE_LIMIT)
          r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
      end
    end
  end
`else
  assign w_defer_act = 1'b0;
`endif

  assign arb__dma__grant            = r_grant;
  assign arb__dma__read_data_valid  = r_dma_rdv;
  assign arb__ldst__granted         = r_granted;
  assign arb__ldst__read_data_valid = r_ldst_rdv;
  assign arb__mem__valid            = r_mem_valid;
  assign arb__mem__we               = r_mem_we;
  assign arb__mem__addr             = r_mem_addr;
  assign arb__mem__wdata            = r_mem_wdata;
  assign arb__rdata                 = mem__arb__rdata;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset_poweron && ldst__arb__valid)
      assert (r_state == S_LDST);
  end
`endif

endmodule

// File: tb/tb_mem_acc_arbiter.sv
// Self-checking bench for mem_acc_arbiter: directed scenarios then randomized traffic
// checked every cycle against a timeline-based reference model.
module tb_mem_acc_arbiter;
  localparam int N = 4, AW = 24, DW = 32, LAT = 3;
  localparam int FREE = 0, DRAIN = 1, LOCK = 2, GAP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, we_v, grant, rdv;
  logic [N*AW-1:0] addr_v;
  logic [N*DW-1:0] wdata_v;
  logic          l_req, l_rel, l_valid, l_we, granted, l_rdv, m_valid, m_we;
  logic [AW-1:0] l_addr, m_addr;
  logic [DW-1:0] l_wdata, m_wdata, m_rdata, rdata;
`ifdef MEM_ACC_ARB_STARVE_GUARD_EN
  logic          defer;
`endif

  always #5 clk = ~clk;

  mem_acc_arbiter #(.NUM_DMA(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_poweron(rst),
    .dma__arb__req(req), .dma__arb__we(we_v), .dma__arb__addr(addr_v), .dma__arb__wdata(wdata_v),
    .arb__dma__grant(grant), .arb__dma__read_data_valid(rdv),
    .ldst__arb__request(l_req), .ldst__arb__released(l_rel), .ldst__arb__valid(l_valid),
    .ldst__arb__we(l_we), .ldst__arb__addr(l_addr), .ldst__arb__wdata(l_wdata),
    .arb__ldst__granted(granted), .arb__ldst__read_data_valid(l_rdv),
`ifdef MEM_ACC_ARB_STARVE_GUARD_EN
    .arb__starve_defer(defer),
`endif
    .arb__mem__valid(m_valid), .arb__mem__we(m_we), .arb__mem__addr(m_addr),
    .arb__mem__wdata(m_wdata), .mem__arb__rdata(m_rdata), .arb__rdata(rdata)
  );

  int n_vec = 0, n_fail = 0;

  // Reference model: access mode, RR pointer, streams owed a grant, and a timeline of returns
  int            md_mode, md_ptr, md_cyc, md_last_ret;
  logic [N-1:0]  md_owed;
  logic [N-1:0]  ret_dma [64];
  logic          ret_ldst [64];
  logic [N-1:0]  e_grant, e_rdv;
  logic          e_granted, e_valid, e_we, e_lrdv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic          auto_clr;
  int            l_ops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i);
    req[i]                = 1'b1;
    we_v[i]               = 1'($urandom_range(0, 1));
    addr_v[i*AW +: AW]    = AW'($urandom);
    wdata_v[i*DW +: DW]   = $urandom;
  endtask

  task automatic record_read(input logic is_ldst, input int idx);
    int slot;
    slot = (md_cyc + LAT) % 64;
    if (is_ldst) ret_ldst[slot] = 1'b1;
    else         ret_dma[slot][idx] = 1'b1;
    md_last_ret = md_cyc + LAT;
  endtask

  task automatic dma_issue(input int sel);
    e_grant       = '0;
    e_grant[sel]  = 1'b1;
    e_valid       = 1'b1;
    e_we          = we_v[sel];
    e_addr        = addr_v[sel*AW +: AW];
    e_wdata       = wdata_v[sel*DW +: DW];
    md_ptr        = (sel + 1) % N;
    if (!we_v[sel]) record_read(1'b0, sel);
  endtask

  // One clock: predict from the inputs now driven, clock, then compare
  task automatic tick();
    int sel, idx, slot;
    logic was_gap, was_rst;
    sel = -1; e_valid = 1'b0; e_grant = '0;
    was_gap = (md_mode == GAP);
    was_rst = rst;
    slot = md_cyc % 64;
    m_rdata = $urandom;
    if (rst) begin
      md_mode = FREE; md_ptr = 0; md_owed = '0; md_last_ret = -100;
      for (int i = 0; i < 64; i++) begin ret_dma[i] = '0; ret_ldst[i] = 1'b0; end
      e_rdv = '0; e_lrdv = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    end else begin
      e_rdv = ret_dma[slot]; e_lrdv = ret_ldst[slot];
      ret_dma[slot] = '0; ret_ldst[slot] = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (md_ptr + k) % N;
        if (sel < 0 && req[idx]) sel = idx;
      end
      case (md_mode)
        FREE: begin
          if (l_req && md_owed == '0) md_mode = DRAIN;
          else if (sel >= 0)          dma_issue(sel);
        end
        GAP: begin
          if (sel >= 0) dma_issue(sel);
          md_mode = FREE;
        end
        DRAIN: if (md_cyc > md_last_ret) md_mode = LOCK;
        default: begin
          if (l_valid) begin
            e_valid = 1'b1; e_we = l_we; e_addr = l_addr; e_wdata = l_wdata;
            if (!l_we) record_read(1'b1, 0);
          end
          if (l_rel) md_mode = GAP;
        end
      endcase
      md_owed = was_gap ? (req & ~e_grant) : (md_owed & ~e_grant);
    end
    e_granted = (md_mode == LOCK);
    @(posedge clk); #1;
    chk("grant", grant, e_grant);
    chk("mem_valid", m_valid, e_valid);
    chk("granted", granted, e_granted);
    chk("dma_rdv", rdv, e_rdv);
    chk("ldst_rdv", l_rdv, e_lrdv);
    chk("rdata", rdata, m_rdata);
    if (e_valid || was_rst) begin
      chk("mem_we", m_we, e_we);
      chk("mem_addr", m_addr, e_addr);
      chk("mem_wdata", m_wdata, e_wdata);
    end
    md_cyc++;
    if (auto_clr) req = req & ~e_grant;
  endtask

  initial begin
    rst = 1'b1; req = '0; we_v = '0; addr_v = '0; wdata_v = '0;
    l_req = 0; l_rel = 0; l_valid = 0; l_we = 0; l_addr = '0; l_wdata = '0; m_rdata = '0;
    auto_clr = 1'b1; md_cyc = 0; md_mode = FREE; md_ptr = 0; md_owed = '0; md_last_ret = -100;
    l_ops = 0;
    tick(); tick();
    rst = 1'b0;

    // Round-robin with all requests held high
    auto_clr = 1'b0;
    for (int i = 0; i < N; i++) set_req(i);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_order", grant, 64'(1) << (i % N));
    end
    req = '0; auto_clr = 1'b1;
    repeat (LAT + 1) tick();

    // Single read from stream 2 returns after RD_LAT
    set_req(2); we_v[2] = 1'b0;
    tick(); chk("tag_grant", grant, 64'h4);
    tick(); tick(); tick(); chk("tag_rdv", rdv, 64'h4);
    tick(); chk("tag_rdv_once", rdv, 64'h0);

    // Lock request while a stream-1 read is in flight
    set_req(1); we_v[1] = 1'b0;
    tick(); chk("drain_grant", grant, 64'h2);
    l_req = 1'b1; set_req(3);
    tick(); chk("drain_nogrant", grant, 64'h0);
    tick(); chk("drain_wait", granted, 64'h0);
    tick(); chk("drain_rdv", rdv, 64'h2); chk("drain_wait2", granted, 64'h0);
    tick(); chk("drain_granted", granted, 64'h1);

    // LDST session: two writes, one read, then release
    l_valid = 1'b1; l_we = 1'b1; l_addr = AW'($urandom); l_wdata = $urandom;
    tick(); chk("ldst_w1", {m_valid, m_we, m_addr}, {1'b1, 1'b1, l_addr});
    l_addr = AW'($urandom); l_wdata = $urandom;
    tick(); chk("ldst_w2", {m_valid, m_we, m_wdata}, {1'b1, 1'b1, l_wdata});
    l_we = 1'b0; l_addr = AW'($urandom);
    tick(); chk("ldst_rd", {m_valid, m_we, m_addr}, {1'b1, 1'b0, l_addr});
    l_valid = 1'b0; l_rel = 1'b1; l_req = 1'b0;
    tick(); chk("ldst_drop", granted, 64'h0); chk("gap_nogrant", grant, 64'h0);
    l_rel = 1'b0;
    tick(); chk("gap_then_s3", grant, 64'h8);
    tick(); chk("ldst_rdv", l_rdv, 64'h1);
    repeat (LAT + 1) tick();

    // Reset in the middle of a read
    set_req(1); we_v[1] = 1'b0;
    tick(); chk("rst_pre_grant", grant, 64'h2);
    rst = 1'b1; req = '0;
    tick(); chk("rst_outs", {grant, rdv, granted, l_rdv, m_valid, m_addr}, 64'h0);
    rst = 1'b0;
    repeat (LAT + 1) begin tick(); chk("rst_no_rdv", rdv, 64'h0); end
    for (int i = 0; i < N; i++) set_req(i);
    tick(); chk("rst_ptr", grant, 64'h1);

    // Randomized traffic with occasional lock sessions and stray releases
    for (int c = 0; c < 600; c++) begin
      l_rel = 1'b0; l_valid = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) set_req(i);
      if (!l_req && $urandom_range(0, 23) == 0) begin
        l_req = 1'b1; l_ops = $urandom_range(1, 3);
      end else if (l_req && e_granted) begin
        if (l_ops > 0) begin
          l_valid = 1'b1; l_we = 1'($urandom_range(0, 1));
          l_addr = AW'($urandom); l_wdata = $urandom; l_ops--;
        end else begin
          l_rel = 1'b1; l_req = 1'b0;
        end
      end else if (!l_req && $urandom_range(0, 31) == 0) begin
        l_rel = 1'b1;
      end
      tick();
    end
    l_rel = 1'b0; l_valid = 1'b0; l_req = 1'b0; req = '0;
    repeat (LAT + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
